// File: rtl/pipe_ctrl_unit.sv
// rtl/pipe_ctrl_unit.sv - RV32I decode-stage control: opcode decode, hazard stall/flush, ID/EX control register, perf counters
// Produces the ID/EX control bundle one cycle after decode and gates the front end on hazards and redirects.
module pipe_ctrl_unit #(
    parameter int RF_ADDR_W = 5,
    parameter int ALUOP_W   = 3,
    parameter int FWD_EN    = 1,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 id_valid,
    input  logic [4:0]           id_opcode,
    input  logic [RF_ADDR_W-1:0] id_rs1,
    input  logic [RF_ADDR_W-1:0] id_rs2,
    input  logic [RF_ADDR_W-1:0] id_rd,
    input  logic [RF_ADDR_W-1:0] mem_rd,
    input  logic                 mem_regwrite,
    input  logic                 ex_redirect,
    output logic                 ex_valid,
    output logic                 ex_branch,
    output logic                 ex_jump,
    output logic                 ex_memread,
    output logic                 ex_memtoreg,
    output logic                 ex_memwrite,
    output logic                 ex_alusrc,
    output logic                 ex_regwrite,
    output logic [ALUOP_W-1:0]   ex_aluop,
    output logic [RF_ADDR_W-1:0] ex_rd,
    output logic                 pc_write,
    output logic                 ifid_write,
    output logic                 ifid_flush,
    output logic                 illegal_inst,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     flush_cnt
);

    localparam logic [4:0] OP_R     = 5'b01100;
    localparam logic [4:0] OP_IARITH = 5'b00100;
    localparam logic [4:0] OP_LW    = 5'b00000;
    localparam logic [4:0] OP_SW    = 5'b01000;
    localparam logic [4:0] OP_BR    = 5'b11000;
    localparam logic [4:0] OP_JAL   = 5'b11011;
    localparam logic [4:0] OP_JALR  = 5'b11001;
    localparam logic [4:0] OP_LUI   = 5'b01101;
    localparam logic [4:0] OP_AUIPC = 5'b00101;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef struct packed {
        logic               branch;
        logic               jump;
        logic               memread;
        logic               memtoreg;
        logic               memwrite;
        logic               alusrc;
        logic               regwrite;
        logic [ALUOP_W-1:0] aluop;
    } ctrl_t;

    ctrl_t                dec;
    logic                 dec_legal;
    logic                 uses_rs1;
    logic                 uses_rs2;

    ctrl_t                ctrl_q, ctrl_d;
    logic                 valid_q, valid_d;
    logic [RF_ADDR_W-1:0] rd_q, rd_d;
    logic                 illegal_q, illegal_d;
    logic [CNT_W-1:0]     stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]     flush_cnt_q, flush_cnt_d;

    logic                 ex_hit;
    logic                 mem_hit;
    logic                 raw_stall;
    logic                 stall;
    logic                 load_bundle;

    always_comb begin
        dec       = '0;
        dec_legal = 1'b1;
        uses_rs1  = 1'b0;
        uses_rs2  = 1'b0;
        case (id_opcode)
            OP_R: begin
                dec.regwrite = 1'b1;
                dec.aluop    = ALUOP_W'(3'b010);
                uses_rs1     = 1'b1;
                uses_rs2     = 1'b1;
            end
            OP_IARITH: begin
                dec.alusrc   = 1'b1;
                dec.regwrite = 1'b1;
                dec.aluop    = ALUOP_W'(3'b011);
                uses_rs1     = 1'b1;
            end
            OP_LW: begin
                dec.memread  = 1'b1;
                dec.memtoreg = 1'b1;
                dec.alusrc   = 1'b1;
                dec.regwrite = 1'b1;
                uses_rs1     = 1'b1;
            end
            OP_SW: begin
                dec.memwrite = 1'b1;
                dec.alusrc   = 1'b1;
                uses_rs1     = 1'b1;
                uses_rs2     = 1'b1;
            end
            OP_BR: begin
                dec.branch = 1'b1;
                dec.aluop  = ALUOP_W'(3'b001);
                uses_rs1   = 1'b1;
                uses_rs2   = 1'b1;
            end
            OP_JAL: begin
                dec.jump     = 1'b1;
                dec.regwrite = 1'b1;
            end
            OP_JALR: begin
                dec.jump     = 1'b1;
                dec.alusrc   = 1'b1;
                dec.regwrite = 1'b1;
                uses_rs1     = 1'b1;
            end
            OP_LUI: begin
                dec.alusrc   = 1'b1;
                dec.regwrite = 1'b1;
                dec.aluop    = ALUOP_W'(3'b100);
            end
            OP_AUIPC: begin
                dec.alusrc   = 1'b1;
                dec.regwrite = 1'b1;
                dec.aluop    = ALUOP_W'(3'b101);
            end
            default: dec_legal = 1'b0;
        endcase
    end

    // x0 never creates a dependency, so a zero destination cannot match.
    assign ex_hit = valid_q & ctrl_q.regwrite & (rd_q != '0) &
                    ((uses_rs1 & (rd_q == id_rs1)) | (uses_rs2 & (rd_q == id_rs2)));
    assign mem_hit = mem_regwrite & (mem_rd != '0) &
                     ((uses_rs1 & (mem_rd == id_rs1)) | (uses_rs2 & (mem_rd == id_rs2)));

    assign raw_stall = (FWD_EN != 0) ? (id_valid & ctrl_q.memread & ex_hit)
                                     : (id_valid & (ex_hit | mem_hit));

    // A redirect squashes the instruction in ID, so its stall is moot.
    assign stall       = raw_stall & ~ex_redirect;
    assign load_bundle = id_valid & dec_legal & ~stall & ~ex_redirect;

    assign pc_write   = rst_n & ~stall;
    assign ifid_write = rst_n & ~stall;
    assign ifid_flush = rst_n & ex_redirect;

    always_comb begin
        ctrl_d      = '0;
        valid_d     = 1'b0;
        rd_d        = '0;
        illegal_d   = id_valid & ~dec_legal & ~ex_redirect;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (load_bundle) begin
            ctrl_d  = dec;
            valid_d = 1'b1;
            rd_d    = id_rd;
        end
        if (stall && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
        if (ex_redirect && !(&flush_cnt_q)) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q      <= '0;
            valid_q     <= 1'b0;
            rd_q        <= '0;
            illegal_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ctrl_q      <= ctrl_d;
            valid_q     <= valid_d;
            rd_q        <= rd_d;
            illegal_q   <= illegal_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign ex_valid     = valid_q;
    assign ex_branch    = ctrl_q.branch;
    assign ex_jump      = ctrl_q.jump;
    assign ex_memread   = ctrl_q.memread;
    assign ex_memtoreg  = ctrl_q.memtoreg;
    assign ex_memwrite  = ctrl_q.memwrite;
    assign ex_alusrc    = ctrl_q.alusrc;
    assign ex_regwrite  = ctrl_q.regwrite;
    assign ex_aluop     = ctrl_q.aluop;
    assign ex_rd        = rd_q;
    assign illegal_inst = illegal_q;
    assign stall_cnt    = stall_cnt_q;
    assign flush_cnt    = flush_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// tb/tb_pipe_ctrl_unit.sv - directed self-checking bench for pipe_ctrl_unit
module tb_pipe_ctrl_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       id_valid = 1'b0;
    logic [4:0] id_opcode = 5'b0;
    logic [4:0] id_rs1 = 5'b0;
    logic [4:0] id_rs2 = 5'b0;
    logic [4:0] id_rd = 5'b0;
    logic       ex_redirect = 1'b0;
    logic [4:0] mem_rd_m;
    logic       mem_rw_m;

    int checks = 0;
    int errors = 0;

    // Instance A: forwarding, 4-bit counters. Instance B: no forwarding, 16-bit counters.
    logic       a_valid, a_branch, a_jump, a_memread, a_memtoreg, a_memwrite, a_alusrc, a_regwrite;
    logic [2:0] a_aluop;
    logic [4:0] a_rd;
    logic       a_pc_write, a_ifid_write, a_ifid_flush, a_illegal;
    logic [3:0] a_stall_cnt, a_flush_cnt;
    logic       b_valid, b_branch, b_jump, b_memread, b_memtoreg, b_memwrite, b_alusrc, b_regwrite;
    logic [2:0] b_aluop;
    logic [4:0] b_rd;
    logic       b_pc_write, b_ifid_write, b_ifid_flush, b_illegal;
    logic [15:0] b_stall_cnt, b_flush_cnt;

    logic [10:0] a_bundle;
    assign a_bundle = {a_valid, a_branch, a_jump, a_memread, a_memtoreg, a_memwrite,
                       a_alusrc, a_regwrite, a_aluop};

    pipe_ctrl_unit #(.RF_ADDR_W(5), .ALUOP_W(3), .FWD_EN(1), .CNT_W(4)) u_fwd (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .mem_rd(mem_rd_m), .mem_regwrite(mem_rw_m), .ex_redirect(ex_redirect),
        .ex_valid(a_valid), .ex_branch(a_branch), .ex_jump(a_jump), .ex_memread(a_memread),
        .ex_memtoreg(a_memtoreg), .ex_memwrite(a_memwrite), .ex_alusrc(a_alusrc),
        .ex_regwrite(a_regwrite), .ex_aluop(a_aluop), .ex_rd(a_rd),
        .pc_write(a_pc_write), .ifid_write(a_ifid_write), .ifid_flush(a_ifid_flush),
        .illegal_inst(a_illegal), .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
    );

    pipe_ctrl_unit #(.RF_ADDR_W(5), .ALUOP_W(3), .FWD_EN(0), .CNT_W(16)) u_nof (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .mem_rd(mem_rd_m), .mem_regwrite(mem_rw_m), .ex_redirect(ex_redirect),
        .ex_valid(b_valid), .ex_branch(b_branch), .ex_jump(b_jump), .ex_memread(b_memread),
        .ex_memtoreg(b_memtoreg), .ex_memwrite(b_memwrite), .ex_alusrc(b_alusrc),
        .ex_regwrite(b_regwrite), .ex_aluop(b_aluop), .ex_rd(b_rd),
        .pc_write(b_pc_write), .ifid_write(b_ifid_write), .ifid_flush(b_ifid_flush),
        .illegal_inst(b_illegal), .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
    );

    always #5 clk = ~clk;

    // EX/MEM stage model fed from instance B's ID/EX outputs.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_rd_m <= 5'd0;
            mem_rw_m <= 1'b0;
        end else begin
            mem_rd_m <= b_rd;
            mem_rw_m <= b_regwrite & b_valid;
        end
    end

    task automatic drive(input logic v, input logic [4:0] op, input logic [4:0] r1,
                         input logic [4:0] r2, input logic [4:0] rd);
        @(negedge clk);
        id_valid  = v;
        id_opcode = op;
        id_rs1    = r1;
        id_rs2    = r2;
        id_rd     = rd;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        id_valid = 1'b0;
        ex_redirect = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({a_bundle, a_rd, a_illegal, a_stall_cnt, a_flush_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_regs got %h exp 0", {a_bundle, a_rd, a_illegal, a_stall_cnt, a_flush_cnt});
        end
        checks++;
        if ({a_pc_write, a_ifid_write, a_ifid_flush} !== 3'b000) begin
            errors++;
            $display("FAIL reset_comb got %b exp 000", {a_pc_write, a_ifid_write, a_ifid_flush});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_decode();
        logic [4:0] ops [9];
        logic [9:0] exp [9];
        ops = '{5'b01100, 5'b00100, 5'b00000, 5'b01000, 5'b11000,
                5'b11011, 5'b11001, 5'b01101, 5'b00101};
        exp = '{10'b0000001_010, 10'b0000011_011, 10'b0011011_000, 10'b0000110_000,
                10'b1000000_001, 10'b0100001_000, 10'b0100011_000, 10'b0000011_100,
                10'b0000011_101};
        do_reset();
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, ops[i], 5'd0, 5'd0, 5'(i + 1));
            tick();
            checks++;
            if ({a_bundle, a_rd, a_illegal} !== {1'b1, exp[i], 5'(i + 1), 1'b0}) begin
                errors++;
                $display("FAIL decode_%b got %h exp %h", ops[i], {a_bundle, a_rd, a_illegal},
                         {1'b1, exp[i], 5'(i + 1), 1'b0});
            end
        end
        drive(1'b1, 5'b11111, 5'd0, 5'd0, 5'd7);
        tick();
        checks++;
        if ({a_bundle, a_illegal} !== {11'd0, 1'b1}) begin
            errors++;
            $display("FAIL illegal_decode got %h exp %h", {a_bundle, a_illegal}, {11'd0, 1'b1});
        end
        drive(1'b0, 5'b01100, 5'd0, 5'd0, 5'd0);
        tick();
        checks++;
        if (a_illegal !== 1'b0) begin
            errors++;
            $display("FAIL illegal_pulse got %b exp 0", a_illegal);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        drive(1'b1, 5'b00000, 5'd1, 5'd0, 5'd5);
        tick();
        drive(1'b1, 5'b01100, 5'd5, 5'd7, 5'd6);
        checks++;
        if ({a_pc_write, a_ifid_write, a_ifid_flush} !== 3'b000) begin
            errors++;
            $display("FAIL loaduse_stall got %b exp 000", {a_pc_write, a_ifid_write, a_ifid_flush});
        end
        tick();
        checks++;
        if ({a_bundle, a_rd} !== 16'd0) begin
            errors++;
            $display("FAIL loaduse_bubble got %h exp 0", {a_bundle, a_rd});
        end
        drive(1'b1, 5'b01100, 5'd5, 5'd7, 5'd6);
        checks++;
        if ({a_pc_write, a_ifid_write} !== 2'b11) begin
            errors++;
            $display("FAIL loaduse_release got %b exp 11", {a_pc_write, a_ifid_write});
        end
        tick();
        checks++;
        if ({a_bundle, a_rd, a_stall_cnt} !== {11'b1_0000001_010, 5'd6, 4'd1}) begin
            errors++;
            $display("FAIL loaduse_issue got %h exp %h", {a_bundle, a_rd, a_stall_cnt},
                     {11'b1_0000001_010, 5'd6, 4'd1});
        end
        drive(1'b1, 5'b00000, 5'd1, 5'd0, 5'd0);
        tick();
        drive(1'b1, 5'b01100, 5'd0, 5'd7, 5'd6);
        checks++;
        if ({a_pc_write, a_stall_cnt} !== {1'b1, 4'd1}) begin
            errors++;
            $display("FAIL loaduse_x0 got %h exp %h", {a_pc_write, a_stall_cnt}, {1'b1, 4'd1});
        end
        tick();
        checks++;
        if ({a_valid, a_rd} !== {1'b1, 5'd6}) begin
            errors++;
            $display("FAIL loaduse_x0_issue got %h exp %h", {a_valid, a_rd}, {1'b1, 5'd6});
        end
    endtask

    task automatic test_no_forward();
        do_reset();
        drive(1'b1, 5'b01100, 5'd0, 5'd0, 5'd3);
        tick();
        drive(1'b1, 5'b01100, 5'd3, 5'd1, 5'd4);
        checks++;
        if ({b_pc_write, b_ifid_write, a_pc_write} !== 3'b001) begin
            errors++;
            $display("FAIL nofwd_ex_stall got %b exp 001", {b_pc_write, b_ifid_write, a_pc_write});
        end
        tick();
        drive(1'b1, 5'b01100, 5'd3, 5'd1, 5'd4);
        checks++;
        if ({b_pc_write, b_ifid_write, b_valid} !== 3'b000) begin
            errors++;
            $display("FAIL nofwd_mem_stall got %b exp 000", {b_pc_write, b_ifid_write, b_valid});
        end
        tick();
        drive(1'b1, 5'b01100, 5'd3, 5'd1, 5'd4);
        checks++;
        if ({b_pc_write, b_valid} !== 2'b10) begin
            errors++;
            $display("FAIL nofwd_release got %b exp 10", {b_pc_write, b_valid});
        end
        tick();
        checks++;
        if ({b_valid, b_rd, b_stall_cnt} !== {1'b1, 5'd4, 16'd2}) begin
            errors++;
            $display("FAIL nofwd_issue got %h exp %h", {b_valid, b_rd, b_stall_cnt}, {1'b1, 5'd4, 16'd2});
        end
    endtask

    task automatic test_redirect();
        do_reset();
        drive(1'b1, 5'b00000, 5'd1, 5'd0, 5'd5);
        tick();
        drive(1'b1, 5'b01100, 5'd5, 5'd7, 5'd6);
        ex_redirect = 1'b1;
        #1;
        checks++;
        if ({a_pc_write, a_ifid_write, a_ifid_flush} !== 3'b111) begin
            errors++;
            $display("FAIL redirect_comb got %b exp 111", {a_pc_write, a_ifid_write, a_ifid_flush});
        end
        tick();
        ex_redirect = 1'b0;
        checks++;
        if ({a_bundle, a_rd, a_flush_cnt, a_stall_cnt} !== {16'd0, 4'd1, 4'd0}) begin
            errors++;
            $display("FAIL redirect_state got %h exp %h", {a_bundle, a_rd, a_flush_cnt, a_stall_cnt},
                     {16'd0, 4'd1, 4'd0});
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 5'b00000, 5'd0, 5'd0, 5'd5);
            tick();
            drive(1'b1, 5'b01100, 5'd5, 5'd7, 5'd6);
            if (i == 19) begin
                checks++;
                if (a_pc_write !== 1'b0) begin
                    errors++;
                    $display("FAIL sat_still_stalls got %b exp 0", a_pc_write);
                end
            end
            tick();
            drive(1'b1, 5'b01100, 5'd5, 5'd7, 5'd6);
            tick();
            if (i == 14) begin
                checks++;
                if (a_stall_cnt !== 4'd15) begin
                    errors++;
                    $display("FAIL sat_reach got %0d exp 15", a_stall_cnt);
                end
            end
        end
        checks++;
        if (a_stall_cnt !== 4'd15) begin
            errors++;
            $display("FAIL sat_hold got %0d exp 15", a_stall_cnt);
        end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        drive(1'b1, 5'b00000, 5'd1, 5'd0, 5'd5);
        tick();
        drive(1'b1, 5'b01100, 5'd5, 5'd7, 5'd6);
        tick();
        drive(1'b1, 5'b01100, 5'd5, 5'd7, 5'd6);
        tick();
        drive(1'b1, 5'b00000, 5'd1, 5'd0, 5'd5);
        tick();
        drive(1'b1, 5'b01100, 5'd5, 5'd7, 5'd6);
        checks++;
        if ({a_pc_write, a_valid, a_stall_cnt} !== {1'b0, 1'b1, 4'd1}) begin
            errors++;
            $display("FAIL midstall_pre got %h exp %h", {a_pc_write, a_valid, a_stall_cnt}, {1'b0, 1'b1, 4'd1});
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({a_bundle, a_rd, a_illegal, a_stall_cnt, a_flush_cnt, a_pc_write, a_ifid_write, a_ifid_flush} !== '0) begin
            errors++;
            $display("FAIL midstall_async got %h exp 0",
                     {a_bundle, a_rd, a_illegal, a_stall_cnt, a_flush_cnt, a_pc_write, a_ifid_write, a_ifid_flush});
        end
        #1 rst_n = 1'b1;
        id_opcode = 5'b00100;
        id_rs1 = 5'd0;
        id_rs2 = 5'd0;
        id_rd = 5'd9;
        #1;
        checks++;
        if ({a_pc_write, a_ifid_write} !== 2'b11) begin
            errors++;
            $display("FAIL midstall_release got %b exp 11", {a_pc_write, a_ifid_write});
        end
        tick();
        checks++;
        if ({a_bundle, a_rd, a_stall_cnt} !== {11'b1_0000011_011, 5'd9, 4'd0}) begin
            errors++;
            $display("FAIL midstall_resume got %h exp %h", {a_bundle, a_rd, a_stall_cnt},
                     {11'b1_0000011_011, 5'd9, 4'd0});
        end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_load_use();
        test_no_forward();
        test_redirect();
        test_saturation();
        test_reset_mid_stall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
